sobel_window_gen: RTL and testbench

//   Streaming 3x3 window generator directly upstream of the Sobel operator.

---
 rtl/sobel_window_gen.sv | 125 ++++++++++++
 tb/tb_sobel_window_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 window generator feeding the Sobel operator
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] pixel_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] p0_o,
  output logic [7:0] p1_o,
  output logic [7:0] p2_o,
  output logic [7:0] p3_o,
  output logic [7:0] p4_o,
  output logic [7:0] p5_o,
  output logic [7:0] p6_o,
  output logic [7:0] p7_o,
  output logic [7:0] p8_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       eof_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // lb1 holds row r-2, lb0 holds row r-1
  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];

  // win[0..2] = top row, win[3..5] = middle row, win[6..8] = bottom row; left to right
  logic [7:0] win [9];

  logic       accept;
  logic       interior;
  logic       last_px;
  logic [7:0] col_top;
  logic [7:0] col_mid;

  // A single output register: room opens when it is empty or being drained this cycle
  assign ready_o  = ready_i | ~valid_o;
  assign accept   = valid_i & ready_o;

  // Read before write: both buffers are sampled at the current column ahead of the update
  assign col_top  = lb1[col];
  assign col_mid  = lb0[col];

  assign interior = (row >= ROW_TWO) && (col >= COL_TWO);
  assign last_px  = (row == ROW_LAST) && (col == COL_LAST);

  // Raster position of the next pixel to be accepted, wrapping at end of row and frame
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers push one row down per accepted pixel; contents need no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col] <= col_mid;
      lb0[col] <= pixel_i;
    end
  end

  // Window shifts left on every accept, new column enters on the right
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 9; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= col_top;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= col_mid;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pixel_i;
    end
  end

  // Window qualifiers: load on accept, clear on drain, hold while stalled
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      eof_o   <= 1'b0;
    end else if (accept) begin
      valid_o <= interior;
      eof_o   <= last_px;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      eof_o   <= 1'b0;
    end
  end

  assign p0_o = win[0];
  assign p1_o = win[1];
  assign p2_o = win[2];
  assign p3_o = win[3];
  assign p4_o = win[4];
  assign p5_o = win[5];
  assign p6_o = win[6];
  assign p7_o = win[7];
  assign p8_o = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen
module tb_sobel_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WB = 8;
  localparam int HB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, vi_a, ro_a, va, ri_a, eo_a;
  logic [7:0] pix_a;
  logic [7:0] pa [9];

  logic       rst_b, vi_b, ro_b, vb, ri_b, eo_b;
  logic [7:0] pix_b;
  logic [7:0] pb [9];

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .pixel_i(pix_a), .valid_i(vi_a), .ready_o(ro_a),
    .p0_o(pa[0]), .p1_o(pa[1]), .p2_o(pa[2]), .p3_o(pa[3]), .p4_o(pa[4]),
    .p5_o(pa[5]), .p6_o(pa[6]), .p7_o(pa[7]), .p8_o(pa[8]),
    .valid_o(va), .ready_i(ri_a), .eof_o(eo_a)
  );

  sobel_window_gen #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .pixel_i(pix_b), .valid_i(vi_b), .ready_o(ro_b),
    .p0_o(pb[0]), .p1_o(pb[1]), .p2_o(pb[2]), .p3_o(pb[3]), .p4_o(pb[4]),
    .p5_o(pb[5]), .p6_o(pb[6]), .p7_o(pb[7]), .p8_o(pb[8]),
    .valid_o(vb), .ready_i(ri_b), .eof_o(eo_b)
  );

  int applied = 0;
  int miscompares = 0;
  logic [72:0] qa[$];
  logic [72:0] qb[$];
  int wins_a = 0, eofs_a = 0, wins_b = 0, eofs_b = 0;
  logic prev_va = 1'b0, prev_acc_a = 1'b0;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    applied++;
    miscompares++;
    $display("FAIL %s: got no event expected one", name);
  endtask

  function automatic logic [72:0] ramp_win(input int base, input int r, input int c, input bit eof);
    logic [72:0] w;
    w[72] = eof;
    for (int k = 0; k < 9; k++) begin
      w[71-8*k -: 8] = 8'(base + 10*(r - 2 + k/3) + (c - 2 + k%3));
    end
    return w;
  endfunction

  function automatic logic [72:0] pack_a();
    return {eo_a, pa[0], pa[1], pa[2], pa[3], pa[4], pa[5], pa[6], pa[7], pa[8]};
  endfunction

  function automatic logic [72:0] pack_b();
    return {eo_b, pb[0], pb[1], pb[2], pb[3], pb[4], pb[5], pb[6], pb[7], pb[8]};
  endfunction

  task automatic push_ramp(input int base);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        qa.push_back(ramp_win(base, r, c, (r == H-1) && (c == W-1)));
  endtask

  task automatic send_a(input logic [7:0] pix);
    int t;
    t = 0;
    pix_a = pix;
    vi_a  = 1'b1;
    @(negedge clk);
    while (!ro_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("send_a_timeout");
    @(posedge clk);
    #1;
    vi_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] pix);
    int t;
    t = 0;
    pix_b = pix;
    vi_b  = 1'b1;
    @(negedge clk);
    while (!ro_b && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail_now("send_b_timeout");
    @(posedge clk);
    #1;
    vi_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the 5x4 instance: pops on every completed window handshake
  always @(negedge clk) begin
    if (!rst_a) begin
      if (va && ri_a) begin
        wins_a++;
        if (eo_a) eofs_a++;
        if (qa.size() == 0) fail_now("unexpected_window_a");
        else chk("window_a", pack_a(), qa.pop_front());
      end
      if (va && !prev_va) chk_bit("valid_rise_has_accept_a", prev_acc_a, 1'b1);
      if (eo_a && !va) chk_bit("eof_without_valid_a", eo_a, 1'b0);
    end
    prev_va    = va;
    prev_acc_a = vi_a && ro_a;
  end

  // Monitor for the 8x6 instance
  always @(negedge clk) begin
    if (!rst_b && vb && ri_b) begin
      wins_b++;
      if (eo_b) eofs_b++;
      if (qb.size() == 0) fail_now("unexpected_window_b");
      else chk("window_b", pack_b(), qb.pop_front());
    end
  end

  initial begin
    logic [72:0] cur;
    logic [72:0] snap;
    logic [71:0] lit_first;
    logic [71:0] lit_second;
    int w0, e0;

    lit_first  = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
    lit_second = {8'd100, 8'd101, 8'd102, 8'd110, 8'd111, 8'd112, 8'd120, 8'd121, 8'd122};

    rst_a = 1'b1; vi_a = 1'b0; pix_a = '0; ri_a = 1'b1;
    rst_b = 1'b1; vi_b = 1'b0; pix_b = '0; ri_b = 1'b1;
    idle(2);
    chk("reset_outputs", pack_a(), '0);
    chk_bit("reset_valid", va, 1'b0);
    chk_bit("reset_ready", ro_a, 1'b1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(1);

    // Test 1: ramp frame at full rate
    w0 = wins_a; e0 = eofs_a;
    push_ramp(0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_a(8'(10*r + c));
        if (r == 2 && c == 2) begin
          cur = pack_a();
          chk_bit("t1_first_valid", va, 1'b1);
          chk("t1_first_window", {1'b0, cur[71:0]}, {1'b0, lit_first});
        end
        if (r == H-1 && c == W-1) begin
          chk_int("t1_last_p8", int'(pa[8]), 34);
          chk_bit("t1_last_eof", eo_a, 1'b1);
        end
      end
    end
    idle(3);
    chk_int("t1_windows", wins_a - w0, 6);
    chk_int("t1_eofs", eofs_a - e0, 1);

    // Test 2: three-cycle downstream stall while a window is held
    w0 = wins_a;
    push_ramp(0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_a(8'(10*r + c));
        if (r == 2 && c == 3) begin
          chk_bit("t2_valid_before_stall", va, 1'b1);
          snap  = pack_a();
          ri_a  = 1'b0;
          vi_a  = 1'b1;
          pix_a = 8'd24;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk_bit("t2_stall_ready", ro_a, 1'b0);
            chk_bit("t2_stall_valid", va, 1'b1);
            chk("t2_stall_hold", pack_a(), snap);
            @(posedge clk);
            #1;
          end
          ri_a = 1'b1;
          vi_a = 1'b0;
        end
      end
    end
    idle(3);
    chk_int("t2_windows", wins_a - w0, 6);

    // Test 3: valid_i toggling
    w0 = wins_a;
    push_ramp(0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_a(8'(10*r + c));
        idle(1);
      end
    end
    idle(3);
    chk_int("t3_windows", wins_a - w0, 6);

    // Test 4: two frames back to back
    w0 = wins_a; e0 = eofs_a;
    push_ramp(0);
    push_ramp(100);
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          send_a(8'(100*f + 10*r + c));
          if (f == 1 && r < 2) chk_bit("t4_no_window_rows01", va, 1'b0);
          if (f == 1 && r == 2 && c == 2) begin
            cur = pack_a();
            chk("t4_second_first_window", {1'b0, cur[71:0]}, {1'b0, lit_second});
          end
        end
      end
    end
    idle(3);
    chk_int("t4_windows", wins_a - w0, 12);
    chk_int("t4_eofs", eofs_a - e0, 2);

    // Test 5: reset after 12 accepted pixels, then a clean frame
    push_ramp(0);
    for (int i = 0; i < 12; i++) send_a(8'(10*(i / W) + i % W));
    #2;
    rst_a = 1'b1;
    #1;
    chk_bit("t5_async_valid", va, 1'b0);
    chk_bit("t5_async_eof", eo_a, 1'b0);
    qa.delete();
    idle(1);
    rst_a = 1'b0;

    // Reset with a window pending under stall: window dropped immediately
    push_ramp(0);
    for (int i = 0; i < 13; i++) send_a(8'(10*(i / W) + i % W));
    ri_a = 1'b0;
    #2;
    chk_bit("t5_pending_valid", va, 1'b1);
    rst_a = 1'b1;
    #1;
    chk_bit("t5_pending_drop_valid", va, 1'b0);
    chk_bit("t5_pending_drop_eof", eo_a, 1'b0);
    qa.delete();
    idle(1);
    rst_a = 1'b0;
    ri_a  = 1'b1;

    w0 = wins_a; e0 = eofs_a;
    push_ramp(0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_a(8'(10*r + c));
        if (r == 2 && c == 2) begin
          cur = pack_a();
          chk("t5_first_window", {1'b0, cur[71:0]}, {1'b0, lit_first});
        end
      end
    end
    idle(3);
    chk_int("t5_windows", wins_a - w0, 6);
    chk_int("t5_eofs", eofs_a - e0, 1);

    // Test 6: constant 255 on the 8x6 instance
    for (int i = 0; i < 24; i++) qb.push_back({(i == 23) ? 1'b1 : 1'b0, {9{8'hff}}});
    for (int i = 0; i < WB*HB; i++) send_b(8'hff);
    idle(3);
    chk_int("t6_windows", wins_b, 24);
    chk_int("t6_eofs", eofs_b, 1);

    chk_int("scoreboard_a_empty", qa.size(), 0);
    chk_int("scoreboard_b_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
